key_expansion: RTL and testbench
================================

# key_expansion

Sequential AES-128 key schedule engine. It accepts a 128-bit cipher key and generates the 10 round keys, one per clock cycle, using one forward-S-box `sub_word` instance (`enc_or_dec_i` tied to 1). It stores all 11 round keys, including the round-0 key, in an internal bank. The round datapath reads keys by index, in ascending order for encryption and descending order for decryption.

## Interface
- `NUM_ROUNDS`, 10, number of generated round keys; 10 is the only legal value (AES-128).

- `clk_i`  input  1  clock; all state changes on rising edge
- `rst_i`  input  1  reset, asynchronous, active-high
- `start_i`  input  1  request expansion of `key_i`; sampled only when `ready_o`=1
- `key_i`  input  128  cipher key; [127:96] is w0, [31:0] is w3
- `ready_o`  output  1  engine idle, start accepted
- `busy_o`  output  1  expansion in progress
- `keys_valid_o`  output  1  bank holds a complete schedule for the last accepted key
- `rk_sel_i`  input  4  round-key index 0..10
- `round_key_o`  output  128  combinational read `bank[rk_sel_i]`; 0 when `rk_sel_i` > 10

## Operation
- States: IDLE and EXPAND.
- Counters:
  - `rnd`: 4 bits, range 1..10.
  - `rcon`: 8 bits, reset value 8'h01.
- IDLE:
  - `ready_o`=1, `busy_o`=0.
  - When `start_i`=1: `bank[0]` <= `key_i`, `keys_valid_o` <= 0, `rnd` <= 1, `rcon` <= 8'h01, next state EXPAND.
- EXPAND, each cycle:
  - Let p = `bank[rnd-1]` = {w0, w1, w2, w3}.
  - t = `SubWord(RotWord(w3))` ^ {`rcon`, 24'h0}, where `RotWord(w3)` = {w3[23:0], w3[31:24]}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - `bank[rnd]` <= {n0, n1, n2, n3}.
  - `rcon` <= xtime(`rcon`), i.e. shift left by one, XOR with 8'h1B if the MSB was set. Sequence: 01 02 04 08 10 20 40 80 1B 36.
  - If `rnd`==10: next state IDLE, `keys_valid_o` <= 1. Otherwise `rnd` <= `rnd`+1.
- Start handling:
  - `start_i` during EXPAND is ignored and has no side effects; it is not queued.
  - `start_i` in IDLE with `keys_valid_o`=1 restarts expansion. The old schedule is invalidated and overwritten.
- `key_i` is sampled only on the accept edge; later changes have no effect.
- Reset, including mid-expansion:
  - State IDLE, `rnd`=1, `rcon`=8'h01, all bank entries 0.
  - `ready_o`=1, `busy_o`=0, `keys_valid_o`=0, `round_key_o`=0 for any `rk_sel_i`.

## Timing
- Start accepted at edge T:
  - `bank[0]` valid after T.
  - `bank[r]` written at edge T+r, for r=1..10.
  - `busy_o`=1 in cycles T..T+9 (after edge T through edge T+10).
  - `ready_o`=1 and `keys_valid_o`=1 after edge T+10.
  - Total latency: 10 cycles from accept edge to valid schedule.
- Back-to-back throughput: one key per 11 cycles. The next start is accepted at edge T+11 at the earliest.
- `round_key_o` has zero-cycle combinational latency from `rk_sel_i`. A read of an index already written during EXPAND returns the new value.
- `sub_word` is purely combinational inside the cycle; there is no extra pipeline stage.

## Configuration
- `KEY_EXPANSION_STREAM_EN` defined adds three outputs, all reset to 0:
  - `rk_valid_o` (1): pulses for one cycle after each edge that writes `bank[r]`, r=0..10, giving 11 pulses per key.
  - `rk_idx_o` (4): r.
  - `rk_o` (128): the key just written.
- These let an on-the-fly encrypt datapath consume keys without reading the bank.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start in IDLE:
  - `keys_valid_o` rises exactly 10 cycles after the accept edge.
  - sel=1 → a0fafe1788542cb123a339392a6c7605.
  - sel=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - sel=0 → the key itself.
- All-zero key:
  - sel=1 → 62636363626363636263636362636363.
  - sel=10 → b4ef5bcb3e92e21123e951cf6f8f188e.
  - sel=11..15 → 0.
- `start_i` held high with a different key throughout EXPAND:
  - The second key is ignored; the schedule matches the first key.
  - The next accept occurs at edge T+11 and `keys_valid_o` drops after it.
- Assert `rst_i` asynchronously at cycle T+5:
  - Outputs clear immediately.
  - `ready_o`=1, bank reads 0.
  - After release, a fresh start produces the correct FIPS-197 schedule.
- With `KEY_EXPANSION_STREAM_EN` defined:
  - 11 `rk_valid_o` pulses on consecutive cycles, `rk_idx_o` 0..10.
  - `rk_o` at idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.

Source files
------------

// File: rtl/key_expansion.sv
// key_expansion: sequential AES-128 key schedule, one round key per cycle into an 11-entry bank.
// Define KEY_EXPANSION_STREAM_EN to add the rk_valid_o/rk_idx_o/rk_o key stream outputs.
module sub_word (
   input  logic        enc_or_dec_i,
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction
   // multiplicative inverse as a^254; 0 maps to 0 naturally
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] a2;
      logic [7:0] a3;
      logic [7:0] a12;
      logic [7:0] a240;
      a2   = gmul(a, a);
      a3   = gmul(a2, a);
      a12  = gmul(gmul(a3, a3), gmul(a3, a3));
      a240 = gmul(a12, a3);
      for (int i = 0; i < 4; i++) a240 = gmul(a240, a240);
      return gmul(gmul(a240, a12), a2);
   endfunction
   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction
   function automatic logic [7:0] fwd(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction
   function automatic logic [7:0] inv(input logic [7:0] s);
      return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
   endfunction
   for (genvar b = 0; b < 4; b++) begin : g_byte
      assign word_o[8*b +: 8] = enc_or_dec_i ? fwd(word_i[8*b +: 8]) : inv(word_i[8*b +: 8]);
   end
endmodule

module key_expansion #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [127:0] key_i,
   output logic         ready_o,
   output logic         busy_o,
   output logic         keys_valid_o,
`ifdef KEY_EXPANSION_STREAM_EN
   output logic         rk_valid_o,
   output logic [3:0]   rk_idx_o,
   output logic [127:0] rk_o,
`endif
   input  logic [3:0]   rk_sel_i,
   output logic [127:0] round_key_o
);
   typedef enum logic {IDLE, EXPAND} state_t;
   state_t state, state_n;
   logic [127:0] bank [0:NUM_ROUNDS];
   logic [3:0]   rnd;
   logic [7:0]   rcon;
   logic         keys_valid;
   logic [127:0] prev;
   logic [127:0] next_key;
   logic [31:0]  sub;
   logic [31:0]  t;
   logic [31:0]  n0, n1, n2, n3;
   logic         accept;
   logic         last;
   assign accept = (state == IDLE) && start_i;
   assign last   = rnd == NUM_ROUNDS[3:0];
   assign prev   = bank[rnd - 4'd1];
   sub_word u_sub (
      .enc_or_dec_i(1'b1),
      .word_i      ({prev[23:0], prev[31:24]}),
      .word_o      (sub)
   );
   assign t        = sub ^ {rcon, 24'h0};
   assign n0       = prev[127:96] ^ t;
   assign n1       = prev[95:64] ^ n0;
   assign n2       = prev[63:32] ^ n1;
   assign n3       = prev[31:0] ^ n2;
   assign next_key = {n0, n1, n2, n3};
   always_comb state_n = accept ? EXPAND : (state == EXPAND && last) ? IDLE : state;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         for (int i = 0; i <= NUM_ROUNDS; i++) bank[i] <= '0;
         rnd        <= 4'd1;
         rcon       <= 8'h01;
         keys_valid <= 1'b0;
      end else if (accept) begin
         bank[0]    <= key_i;
         keys_valid <= 1'b0;
         rnd        <= 4'd1;
         rcon       <= 8'h01;
      end else if (state == EXPAND) begin
         bank[rnd] <= next_key;
         rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         if (last) keys_valid <= 1'b1;
         else rnd <= rnd + 4'd1;
      end
`ifdef KEY_EXPANSION_STREAM_EN
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         rk_valid_o <= 1'b0;
         rk_idx_o   <= '0;
         rk_o       <= '0;
      end else begin
         rk_valid_o <= accept || state == EXPAND;
         rk_idx_o   <= accept ? 4'd0 : rnd;
         rk_o       <= accept ? key_i : next_key;
      end
`endif
   assign ready_o      = state == IDLE;
   assign busy_o       = state == EXPAND;
   assign keys_valid_o = keys_valid;
   assign round_key_o  = (rk_sel_i <= NUM_ROUNDS[3:0]) ? bank[rk_sel_i] : '0;
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: scoreboard bench for key_expansion (FIPS-197 and all-zero keys, restart, reset).
module tb_key_expansion;
   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         start_i = 1'b0;
   logic [127:0] key_i = '0;
   logic         ready_o, busy_o, keys_valid_o;
   logic [3:0]   rk_sel_i = '0;
   logic [127:0] round_key_o;
`ifdef KEY_EXPANSION_STREAM_EN
   logic         rk_valid_o;
   logic [3:0]   rk_idx_o;
   logic [127:0] rk_o;
`endif
   localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] F1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] F10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z1   = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   typedef struct {logic [3:0] sel; logic [127:0] val;} exp_t;
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   key_expansion dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .key_i       (key_i),
      .ready_o     (ready_o),
      .busy_o      (busy_o),
      .keys_valid_o(keys_valid_o),
`ifdef KEY_EXPANSION_STREAM_EN
      .rk_valid_o  (rk_valid_o),
      .rk_idx_o    (rk_idx_o),
      .rk_o        (rk_o),
`endif
      .rk_sel_i    (rk_sel_i),
      .round_key_o (round_key_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic push(input logic [3:0] sel, input logic [127:0] val);
      exp_t e;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask
   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rk_sel_i = e.sel;
         #1;
         check($sformatf("rk%0d", e.sel), round_key_o, e.val);
      end
   endtask
   task automatic push_fips();
      push(4'd0, FIPS);
      push(4'd1, F1);
      push(4'd10, F10);
   endtask
   task automatic push_zero();
      push(4'd0, '0);
      push(4'd1, Z1);
      push(4'd10, Z10);
      for (int s = 11; s < 16; s++) push(4'(s), '0);
   endtask
   // accept at the posedge between the two negedges; expectations already queued
   task automatic run_key(input logic [127:0] k, input logic [127:0] last_key);
      int n;
      @(negedge clk_i);
      key_i   = k;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      key_i   = ~k;
      check("ready_after_accept", ready_o, 0);
      check("kv_after_accept", keys_valid_o, 0);
      n = 0;
      while (1) begin
         check($sformatf("busy%0d", n), busy_o, n < 10);
`ifdef KEY_EXPANSION_STREAM_EN
         check($sformatf("rkv%0d", n), rk_valid_o, 1);
         check($sformatf("rki%0d", n), rk_idx_o, n);
`endif
         if (keys_valid_o || n == 20) break;
         @(negedge clk_i);
         n++;
      end
      check("latency", n, 10);
      check("ready_done", ready_o, 1);
`ifdef KEY_EXPANSION_STREAM_EN
      check("rk_o10", rk_o, last_key);
`endif
      drain();
`ifdef KEY_EXPANSION_STREAM_EN
      @(negedge clk_i);
      check("rkv_end", rk_valid_o, 0);
`endif
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      int n;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rst_ready", ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_kv", keys_valid_o, 0);
      check("rst_rk0", round_key_o, '0);
      push_fips();
      run_key(FIPS, F10);
      push_zero();
      run_key('0, Z10);
      // start held high with a second key during the whole expansion
      @(negedge clk_i);
      key_i   = FIPS;
      start_i = 1'b1;
      @(negedge clk_i);
      key_i = '0;
      repeat (9) @(negedge clk_i);
      check("hold_busy9", busy_o, 1);
      check("hold_kv9", keys_valid_o, 0);
      @(negedge clk_i);
      check("hold_kv10", keys_valid_o, 1);
      check("hold_ready10", ready_o, 1);
      push(4'd1, F1);
      push(4'd10, F10);
      drain();
      @(negedge clk_i);
      start_i = 1'b0;
      check("hold_kv11", keys_valid_o, 0);
      check("hold_busy11", busy_o, 1);
      push(4'd0, '0);
      drain();
      n = 0;
      while (!keys_valid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check("hold_second_lat", n, 10);
      push_zero();
      drain();
      // asynchronous reset in the middle of an expansion
      @(negedge clk_i);
      key_i   = FIPS;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (4) @(negedge clk_i);
      @(posedge clk_i);
      #2;
      check("pre_rst_busy", busy_o, 1);
      rst_i = 1'b1;
      #1;
      check("mid_rst_ready", ready_o, 1);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_kv", keys_valid_o, 0);
      push(4'd0, '0);
      push(4'd3, '0);
      push(4'd10, '0);
      drain();
`ifdef KEY_EXPANSION_STREAM_EN
      check("mid_rst_rkv", rk_valid_o, 0);
      check("mid_rst_rk", rk_o, '0);
`endif
      @(negedge clk_i);
      rst_i = 1'b0;
      push_fips();
      run_key(FIPS, F10);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
